// File: rtl/slow_clock_serial_shifter.sv
// Frames a WIDTH-bit word MSB-first onto SerClk/SerData/SerCs_n, pacing bits by an asynchronous slow clock input.
// Optional: define SHIFTER_PARITY_EN to append an even-parity bit to each frame.
module slow_clock_serial_shifter #(
   parameter int WIDTH = 16
) (
   input  logic             FiftyIn,
   input  logic             Resetn,
   input  logic             SlowClkIn,
   input  logic [WIDTH-1:0] DataIn,
   input  logic             Load,
   output logic             Busy,
   output logic             Done,
   output logic             SerClk,
   output logic             SerData,
   output logic             SerCs_n
);

   localparam int CW = $clog2(WIDTH + 1);
`ifdef SHIFTER_PARITY_EN
   localparam logic [CW-1:0] LAST_CNT  = CW'(WIDTH);
   localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
`else
   localparam logic [CW-1:0] LAST_CNT  = CW'(WIDTH - 1);
`endif

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALIGN = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

`ifdef SHIFTER_PARITY_EN
   function automatic logic even_parity(input logic [WIDTH-1:0] word);
      return ^word;
   endfunction
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             s0_q, s0_d;
   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             ser_clk_q, ser_clk_d;
   logic             ser_data_q, ser_data_d;
   logic             ser_cs_n_q, ser_cs_n_d;
   logic             fall_s;
`ifdef SHIFTER_PARITY_EN
   logic             par_q, par_d;
`endif

   // Only the falling strobe paces the frame; rising edges of the slow clock are ignored.
   assign fall_s = s2_q & ~s1_q;

   // Next-state and output computation for synchronizer, framing FSM and shifter.
   always_comb begin
      s0_d       = SlowClkIn;
      s1_d       = s0_q;
      s2_d       = s1_q;
      state_d    = state_q;
      sh_d       = sh_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      ser_data_d = ser_data_q;
      ser_cs_n_d = ser_cs_n_q;
`ifdef SHIFTER_PARITY_EN
      par_d      = par_q;
`endif
      if (state_q == ST_SHIFT) begin
         ser_clk_d = s1_q;
      end else begin
         ser_clk_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (Load) begin
               sh_d    = DataIn;
               cnt_d   = {CW{1'b0}};
               busy_d  = 1'b1;
               state_d = ST_ALIGN;
`ifdef SHIFTER_PARITY_EN
               par_d   = even_parity(DataIn);
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ALIGN: begin
            if (fall_s) begin
               ser_cs_n_d = 1'b0;
               ser_data_d = sh_q[WIDTH-1];
               state_d    = ST_SHIFT;
            end else begin
               state_d    = ST_ALIGN;
            end
         end
         ST_SHIFT: begin
            if (fall_s) begin
               if (cnt_q == LAST_CNT) begin
                  ser_cs_n_d = 1'b1;
                  ser_data_d = 1'b0;
                  busy_d     = 1'b0;
                  done_d     = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                  cnt_d = cnt_q + CW'(1);
`ifdef SHIFTER_PARITY_EN
                  if (cnt_q == DATA_LAST) begin
                     ser_data_d = par_q;
                  end else begin
                     ser_data_d = sh_q[WIDTH-2];
                  end
`else
                  ser_data_d = sh_q[WIDTH-2];
`endif
               end
            end else begin
               state_d = ST_SHIFT;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            ser_cs_n_d = 1'b1;
            ser_data_d = 1'b0;
         end
      endcase
   end

   // State registers with synchronous active-low reset; reset aborts any frame in flight.
   always_ff @(posedge FiftyIn) begin
      if (!Resetn) begin
         state_q    <= ST_IDLE;
         sh_q       <= {WIDTH{1'b0}};
         cnt_q      <= {CW{1'b0}};
         s0_q       <= 1'b0;
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ser_clk_q  <= 1'b0;
         ser_data_q <= 1'b0;
         ser_cs_n_q <= 1'b1;
`ifdef SHIFTER_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         sh_q       <= sh_d;
         cnt_q      <= cnt_d;
         s0_q       <= s0_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ser_clk_q  <= ser_clk_d;
         ser_data_q <= ser_data_d;
         ser_cs_n_q <= ser_cs_n_d;
`ifdef SHIFTER_PARITY_EN
         par_q      <= par_d;
`endif
      end
   end

   assign Busy    = busy_q;
   assign Done    = done_q;
   assign SerClk  = ser_clk_q;
   assign SerData = ser_data_q;
   assign SerCs_n = ser_cs_n_q;

endmodule

// File: tb/tb_slow_clock_serial_shifter.sv
// Bench for slow_clock_serial_shifter: a receiver on SerClk rise collects frames, compared to a word-level model.
module tb_slow_clock_serial_shifter;

   localparam int W = 16;
`ifdef SHIFTER_PARITY_EN
   localparam int FLEN = W + 1;
`else
   localparam int FLEN = W;
`endif
   localparam int SLOW_PERIOD = 20;

   logic         FiftyIn;
   logic         Resetn;
   logic         SlowClkIn;
   logic [W-1:0] DataIn;
   logic         Load;
   logic         Busy, Done, SerClk, SerData, SerCs_n;

   int checks, errors;
   int cyc, last_fall_cyc, done_total, clk_viol, cur_len, low_cyc;
   logic [63:0] cur_val;
   logic [63:0] rx_val[$];
   int          rx_len[$], rx_dur[$], rx_delay[$], rx_low[$];
   bit          rx_busy_fell[$], rx_done[$];

   slow_clock_serial_shifter #(.WIDTH(W)) dut (
      .FiftyIn(FiftyIn), .Resetn(Resetn), .SlowClkIn(SlowClkIn), .DataIn(DataIn),
      .Load(Load), .Busy(Busy), .Done(Done), .SerClk(SerClk), .SerData(SerData),
      .SerCs_n(SerCs_n)
   );

   // Expected serial frame: data bits MSB first, then the even parity bit when enabled.
   function automatic logic [63:0] exp_frame(input logic [W-1:0] w);
      logic [63:0] v;
      v = 64'd0;
      for (int i = W - 1; i >= 0; i--) v = v * 2 + 64'(w[i]);
`ifdef SHIFTER_PARITY_EN
      begin
         int ones;
         ones = 0;
         for (int i = 0; i < W; i++) ones += int'(w[i]);
         v = v * 2 + 64'(ones % 2);
      end
`endif
      return v;
   endfunction

   initial begin
      FiftyIn = 1'b0;
      forever #10 FiftyIn = ~FiftyIn;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge FiftyIn);
         cyc++;
      end
   end

   initial begin
      SlowClkIn = 1'b1;
      last_fall_cyc = 0;
      forever begin
         repeat (SLOW_PERIOD / 2) @(negedge FiftyIn);
         SlowClkIn = ~SlowClkIn;
         if (!SlowClkIn) last_fall_cyc = cyc;
      end
   end

   // Receiver: samples SerData on each SerClk rise and records per-frame timing.
   initial begin
      logic prev_csn, prev_clk, prev_busy;
      prev_csn = 1'b1; prev_clk = 1'b0; prev_busy = 1'b0;
      done_total = 0; clk_viol = 0; cur_len = 0; cur_val = 64'd0; low_cyc = 0;
      forever begin
         @(negedge FiftyIn);
         if (Done === 1'b1) done_total++;
         if (SerCs_n === 1'b1 && SerClk !== 1'b0) clk_viol++;
         if (prev_clk === 1'b0 && SerClk === 1'b1) begin
            cur_val = cur_val * 2 + 64'(SerData);
            cur_len++;
         end
         if (prev_csn === 1'b1 && SerCs_n === 1'b0) begin
            cur_val = 64'd0;
            cur_len = 0;
            low_cyc = cyc;
            rx_low.push_back(cyc);
            rx_delay.push_back(cyc - last_fall_cyc);
         end
         if (prev_csn === 1'b0 && SerCs_n === 1'b1) begin
            rx_val.push_back(cur_val);
            rx_len.push_back(cur_len);
            rx_dur.push_back(cyc - low_cyc);
            rx_busy_fell.push_back(prev_busy === 1'b1 && Busy === 1'b0);
            rx_done.push_back(Done === 1'b1);
         end
         prev_csn = SerCs_n; prev_clk = SerClk; prev_busy = Busy;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no summary expected summary");
      $fatal(1);
   end

   task automatic send(input logic [W-1:0] w);
      @(negedge FiftyIn);
      DataIn = w;
      Load   = 1'b1;
      @(negedge FiftyIn);
      Load   = 1'b0;
   endtask

   task automatic wait_frames(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (rx_val.size() >= target) begin
            ok = 1'b1;
            break;
         end
         @(negedge FiftyIn);
      end
   endtask

   task automatic test_reset;
      for (int i = 0; i < 3; i++) begin
         @(negedge FiftyIn);
         checks++;
         if (Busy !== 1'b0 || SerCs_n !== 1'b1 || SerClk !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got Busy=%b SerCs_n=%b SerClk=%b Done=%b expected 0 1 0 0",
                     Busy, SerCs_n, SerClk, Done);
         end
      end
      Resetn = 1'b1;
      Load   = 1'b0;
      repeat (60) @(negedge FiftyIn);
      checks++;
      if (Busy !== 1'b0 || SerCs_n !== 1'b1 || rx_low.size() != 0) begin
         errors++;
         $display("FAIL reset_idle: got Busy=%b SerCs_n=%b frames=%0d expected 0 1 0",
                  Busy, SerCs_n, rx_low.size());
      end
   endtask

   task automatic test_single_frame;
      int base, d0;
      bit ok;
      base = rx_val.size();
      d0   = done_total;
      send(16'hA5C3);
      checks++;
      if (Busy !== 1'b1) begin
         errors++;
         $display("FAIL single_busy: got %b expected 1", Busy);
      end
      wait_frames(base + 1, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL single_timeout: got no frame expected 1 frame");
      end else begin
         checks += 5;
         if (rx_val[base] !== exp_frame(16'hA5C3) || rx_len[base] != FLEN) begin
            errors++;
            $display("FAIL single_data: got %h/%0d bits expected %h/%0d bits",
                     rx_val[base], rx_len[base], exp_frame(16'hA5C3), FLEN);
         end
         if (rx_delay[base] != 3) begin
            errors++;
            $display("FAIL single_align: got %0d cycles expected 3", rx_delay[base]);
         end
         if (rx_dur[base] != FLEN * SLOW_PERIOD) begin
            errors++;
            $display("FAIL single_cs_len: got %0d expected %0d", rx_dur[base], FLEN * SLOW_PERIOD);
         end
         if (!rx_busy_fell[base]) begin
            errors++;
            $display("FAIL single_busy_end: got 0 expected 1 (Busy falls with SerCs_n rise)");
         end
         if (!rx_done[base]) begin
            errors++;
            $display("FAIL single_done_edge: got 0 expected 1");
         end
      end
      repeat (60) @(negedge FiftyIn);
      checks++;
      if (done_total - d0 != 1) begin
         errors++;
         $display("FAIL single_done_count: got %0d expected 1", done_total - d0);
      end
   endtask

   task automatic test_busy_ignore;
      int base, d0;
      bit ok;
      base = rx_val.size();
      d0   = done_total;
      send(16'h0001);
      repeat (100) @(negedge FiftyIn);
      DataIn = 16'hFFFF;
      Load   = 1'b1;
      @(negedge FiftyIn);
      Load   = 1'b0;
      wait_frames(base + 1, ok);
      repeat (400) @(negedge FiftyIn);
      checks++;
      if (!ok || rx_val.size() != base + 1) begin
         errors++;
         $display("FAIL ignore_frames: got %0d frames expected 1", rx_val.size() - base);
      end else begin
         checks++;
         if (rx_val[base] !== exp_frame(16'h0001) || rx_len[base] != FLEN) begin
            errors++;
            $display("FAIL ignore_data: got %h expected %h", rx_val[base], exp_frame(16'h0001));
         end
      end
      checks++;
      if (done_total - d0 != 1 || Busy !== 1'b0) begin
         errors++;
         $display("FAIL ignore_done: got done=%0d Busy=%b expected 1 0", done_total - d0, Busy);
      end
   endtask

   task automatic test_back_to_back;
      int base, done_c;
      bit ok, seen;
      logic [W-1:0] words [2];
      words[0] = 16'h1234;
      words[1] = 16'h8001;
      base = rx_val.size();
      @(negedge FiftyIn);
      DataIn = words[0];
      Load   = 1'b1;
      @(negedge FiftyIn);
      DataIn = words[1];
      seen = 1'b0;
      done_c = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge FiftyIn);
         if (Done === 1'b1) begin
            seen = 1'b1;
            done_c = cyc;
            break;
         end
      end
      @(negedge FiftyIn);
      checks++;
      if (!seen || Busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept: got done_seen=%b Busy=%b expected 1 1", seen, Busy);
      end
      Load = 1'b0;
      wait_frames(base + 2, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL b2b_timeout: got %0d frames expected 2", rx_val.size() - base);
      end else begin
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (rx_val[base+k] !== exp_frame(words[k]) || rx_len[base+k] != FLEN) begin
               errors++;
               $display("FAIL b2b_data%0d: got %h expected %h", k, rx_val[base+k], exp_frame(words[k]));
            end
         end
         checks++;
         if (rx_low[base+1] - done_c != SLOW_PERIOD || rx_delay[base+1] != 3) begin
            errors++;
            $display("FAIL b2b_align: got %0d/%0d cycles expected %0d/3",
                     rx_low[base+1] - done_c, rx_delay[base+1], SLOW_PERIOD);
         end
      end
   endtask

   task automatic test_reset_midframe;
      int base, lbase, d0;
      bit ok, started;
      base  = rx_val.size();
      lbase = rx_low.size();
      d0    = done_total;
      send(16'($urandom));
      started = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge FiftyIn);
         if (rx_low.size() > lbase && cur_len >= 5) begin
            started = 1'b1;
            break;
         end
      end
      repeat (3) @(negedge FiftyIn);
      Resetn = 1'b0;
      @(negedge FiftyIn);
      checks++;
      if (!started || SerCs_n !== 1'b1 || SerClk !== 1'b0 || Done !== 1'b0 || Busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_outputs: got started=%b SerCs_n=%b SerClk=%b Done=%b Busy=%b expected 1 1 0 0 0",
                  started, SerCs_n, SerClk, Done, Busy);
      end
      @(negedge FiftyIn);
      Resetn = 1'b1;
      repeat (60) @(negedge FiftyIn);
      checks++;
      if (done_total != d0 || rx_val.size() != base + 1) begin
         errors++;
         $display("FAIL midreset_abort: got done=%0d frames=%0d expected 0 1",
                  done_total - d0, rx_val.size() - base);
      end else begin
         checks++;
         if (rx_len[base] != 5 || rx_done[base]) begin
            errors++;
            $display("FAIL midreset_bits: got %0d bits done=%b expected 5 0", rx_len[base], rx_done[base]);
         end
      end
      send(16'h00FF);
      wait_frames(base + 2, ok);
      checks++;
      if (!ok || rx_val[base+1] !== exp_frame(16'h00FF) || rx_len[base+1] != FLEN) begin
         errors++;
         $display("FAIL midreset_next: got %h expected %h",
                  ok ? rx_val[base+1] : 64'hx, exp_frame(16'h00FF));
      end
   endtask

   task automatic test_random;
      int d0;
      bit ok;
      logic [W-1:0] w;
      d0 = done_total;
      for (int k = 0; k < 8; k++) begin
         int base;
         base = rx_val.size();
         if (k == 0) w = 16'h0007;
         else if (k == 1) w = 16'h0003;
         else w = 16'($urandom);
         repeat ($urandom_range(0, 40)) @(negedge FiftyIn);
         send(w);
         wait_frames(base + 1, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL rand_timeout%0d: got no frame expected 1", k);
         end else begin
            checks++;
            if (rx_val[base] !== exp_frame(w) || rx_len[base] != FLEN || rx_dur[base] != FLEN * SLOW_PERIOD
                || rx_delay[base] != 3 || !rx_busy_fell[base] || !rx_done[base]) begin
               errors++;
               $display("FAIL rand_frame%0d: got %h/%0d bits dur=%0d delay=%0d bf=%b dn=%b expected %h/%0d bits dur=%0d delay=3 bf=1 dn=1",
                        k, rx_val[base], rx_len[base], rx_dur[base], rx_delay[base], rx_busy_fell[base],
                        rx_done[base], exp_frame(w), FLEN, FLEN * SLOW_PERIOD);
            end
         end
      end
      repeat (30) @(negedge FiftyIn);
      checks++;
      if (done_total - d0 != 8 || clk_viol != 0) begin
         errors++;
         $display("FAIL rand_done_idleclk: got done=%0d serclk_idle_high=%0d expected 8 0",
                  done_total - d0, clk_viol);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      Resetn = 1'b0;
      Load   = 1'b1;
      DataIn = 16'($urandom);
      test_reset;
      test_single_frame;
      test_busy_ignore;
      test_back_to_back;
      test_reset_midframe;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
